// File: rtl/cmp_bsearch.sv
// Binary-search initiator for a magnitude comparator: drives the probe operand and
// narrows [lo, hi] using the gt/lt/eq flags until the target is found or proven unreachable.
module cmp_bsearch #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 0,
    localparam int STEPW = $clog2(WIDTH + 2)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             gt_i,
    input  logic             lt_i,
    input  logic             eq_i,
    output logic [WIDTH-1:0] probe_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] found_o,
    output logic [STEPW-1:0] steps_o,
    output logic             err_o
);

    localparam int WCW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};
    localparam logic [WCW-1:0] WLAST = WCW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   probe_q, probe_d;
    logic [WIDTH-1:0]   found_q, found_d;
    logic [STEPW-1:0]   steps_q, steps_d;
    logic [WCW-1:0]     wait_q, wait_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   nlo_s;
    logic [WIDTH-1:0]   nhi_s;
    logic               next_s;
    logic               fail_s;

    // Midpoint is formed one bit wider so hi-lo never wraps.
    function automatic logic [WIDTH-1:0] mid_f(input logic [WIDTH-1:0] lo,
                                               input logic [WIDTH-1:0] hi);
        logic [WIDTH:0] sum;
        sum = {1'b0, lo} + (({1'b0, hi} - {1'b0, lo}) >> 1);
        return sum[WIDTH-1:0];
    endfunction

    // Next-state and datapath decode for the search controller.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        probe_d = probe_q;
        found_d = found_q;
        steps_d = steps_q;
        wait_d  = wait_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        nlo_s   = lo_q;
        nhi_s   = hi_q;
        next_s  = 1'b0;
        fail_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    lo_d    = WIDTH'(0);
                    hi_d    = MAXV;
                    probe_d = mid_f(WIDTH'(0), MAXV);
                    steps_d = STEPW'(1);
                    busy_d  = 1'b1;
                    found_d = WIDTH'(0);
                    wait_d  = WCW'(0);
                    state_d = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (abort_i) begin
                    busy_d  = 1'b0;
                    wait_d  = WCW'(0);
                    state_d = S_IDLE;
                end else if (wait_q == WLAST) begin
                    wait_d  = WCW'(0);
                    state_d = S_SAMPLE;
                end else begin
                    wait_d  = wait_q + WCW'(1);
                end
            end
            S_SAMPLE: begin
                if (abort_i) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    case ({gt_i, lt_i, eq_i})
                        3'b001: begin
                            found_d = probe_q;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                        3'b100: begin
                            if (probe_q == WIDTH'(0)) begin
                                fail_s = 1'b1;
                            end else begin
                                nhi_s  = probe_q - WIDTH'(1);
                                next_s = 1'b1;
                            end
                        end
                        3'b010: begin
                            if (probe_q == MAXV) begin
                                fail_s = 1'b1;
                            end else begin
                                nlo_s  = probe_q + WIDTH'(1);
                                next_s = 1'b1;
                            end
                        end
                        default: begin
                            fail_s = 1'b1;
                        end
                    endcase

                    // An empty range after narrowing means the target cannot exist.
                    if (next_s && (nlo_s > nhi_s)) begin
                        fail_s = 1'b1;
                    end else begin
                        fail_s = fail_s;
                    end

                    if (fail_s) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (next_s) begin
                        lo_d    = nlo_s;
                        hi_d    = nhi_s;
                        probe_d = mid_f(nlo_s, nhi_s);
                        steps_d = steps_q + STEPW'(1);
                        wait_d  = WCW'(0);
                        state_d = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
                    end else begin
                        steps_d = steps_q;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            lo_q    <= WIDTH'(0);
            hi_q    <= WIDTH'(0);
            probe_q <= WIDTH'(0);
            found_q <= WIDTH'(0);
            steps_q <= STEPW'(0);
            wait_q  <= WCW'(0);
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            probe_q <= probe_d;
            found_q <= found_d;
            steps_q <= steps_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign probe_o = probe_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign found_o = found_q;
    assign steps_o = steps_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_cmp_bsearch.sv
// Bench for cmp_bsearch: two instances (SETTLE=0 and SETTLE=2), each fed by a comparator
// model; a reference binary search predicts the probe sequence and outcome.
module tb_cmp_bsearch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_ni;
    logic       start_s [2];
    logic       abort_s [2];
    logic [2:0] flags_w [2];
    logic [7:0] probe_w [2];
    logic [7:0] found_w [2];
    logic [3:0] steps_w [2];
    logic       busy_w  [2];
    logic       done_w  [2];
    logic       err_w   [2];
    int         mode    [2];
    int         target  [2];

    int checks = 0;
    int failures = 0;

    int exp_seq[$];
    bit exp_ok;
    int exp_steps;

    // Comparator stand-in: mode 0 honest, 1 no flag, 2 gt+lt, 3 always "probe < target".
    function automatic logic [2:0] flags_f(input int md, input int t, input logic [7:0] p);
        case (md)
            0: flags_f = (int'(p) > t) ? 3'b100 : ((int'(p) < t) ? 3'b010 : 3'b001);
            1: flags_f = 3'b000;
            2: flags_f = 3'b110;
            default: flags_f = 3'b010;
        endcase
    endfunction

    assign flags_w[0] = flags_f(mode[0], target[0], probe_w[0]);
    assign flags_w[1] = flags_f(mode[1], target[1], probe_w[1]);

    cmp_bsearch #(.WIDTH(8), .SETTLE(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_s[0]), .abort_i(abort_s[0]),
        .gt_i(flags_w[0][2]), .lt_i(flags_w[0][1]), .eq_i(flags_w[0][0]),
        .probe_o(probe_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]),
        .found_o(found_w[0]), .steps_o(steps_w[0]), .err_o(err_w[0])
    );

    cmp_bsearch #(.WIDTH(8), .SETTLE(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_s[1]), .abort_i(abort_s[1]),
        .gt_i(flags_w[1][2]), .lt_i(flags_w[1][1]), .eq_i(flags_w[1][0]),
        .probe_o(probe_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]),
        .found_o(found_w[1]), .steps_o(steps_w[1]), .err_o(err_w[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference search over integers, in the same mode vocabulary as flags_f.
    function automatic void model(input int md, input int t);
        int lo, hi, p;
        exp_seq.delete();
        exp_ok = 1'b0;
        lo = 0;
        hi = 255;
        for (int guard = 0; guard < 20; guard++) begin
            p = (lo + hi) / 2;
            exp_seq.push_back(p);
            if (md == 1 || md == 2) break;
            if (md == 0 && p == t) begin
                exp_ok = 1'b1;
                break;
            end
            if (md == 0 && p > t) begin
                if (p == 0) break;
                hi = p - 1;
            end else begin
                if (p == 255) break;
                lo = p + 1;
            end
            if (lo > hi) break;
        end
        exp_steps = exp_seq.size();
    endfunction

    // One search on instance k, checked every cycle against the model.
    task automatic run(input int k, input int md, input int t, input int restart_n,
                       input bit pre, input bit chain_out, output int done_n);
        int s;
        int last;
        s = (k == 0) ? 0 : 2;
        model(md, t);
        last = exp_steps * (s + 1);
        done_n = -1;
        mode[k] = md;
        target[k] = t;
        if (!pre) begin
            @(negedge clk);
            start_s[k] = 1'b1;
        end
        for (int n = 1; n <= last + 2; n++) begin
            @(negedge clk);
            start_s[k] = 1'b0;
            if (done_w[k] && done_n < 0) done_n = n;
            if (n <= last) begin
                chk("busy", int'(busy_w[k]), 1);
                chk("probe", int'(probe_w[k]), exp_seq[(n - 1) / (s + 1)]);
                chk("pulse_in_search", int'({done_w[k], err_w[k]}), 0);
                if (n == restart_n) start_s[k] = 1'b1;
            end else if (n == last + 1) begin
                chk("busy_end", int'(busy_w[k]), 0);
                chk("done", int'(done_w[k]), int'(exp_ok));
                chk("err", int'(err_w[k]), int'(!exp_ok));
                chk("found", int'(found_w[k]), exp_ok ? t : 0);
                chk("steps", int'(steps_w[k]), exp_steps);
                if (chain_out) begin
                    start_s[k] = 1'b1;
                    return;
                end
            end else begin
                chk("pulse_after", int'({done_w[k], err_w[k]}), 0);
                chk("busy_after", int'(busy_w[k]), 0);
            end
        end
    endtask

    int lit_seq[8] = '{127, 63, 95, 111, 103, 99, 101, 100};
    int dn;

    initial begin
        rst_ni = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0;
            abort_s[k] = 1'b0;
            mode[k] = 0;
            target[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_probe", int'(probe_w[k]), 0);
            chk("rst_flags", int'({busy_w[k], done_w[k], err_w[k]}), 0);
            chk("rst_found_steps", int'({found_w[k], steps_w[k]}), 0);
        end
        rst_ni = 1'b1;

        // Pin the reference search itself against hand-derived values.
        model(0, 100);
        chk("model_len100", exp_steps, 8);
        for (int i = 0; i < 8; i++) chk("model_seq100", exp_seq[i], lit_seq[i]);
        model(3, 0);
        chk("model_liar_len", exp_steps, 9);
        chk("model_liar_last", exp_seq[8], 255);

        run(0, 0, 100, 0, 1'b0, 1'b0, dn);
        chk("t1_found", int'(found_w[0]), 100);
        chk("t1_steps", int'(steps_w[0]), 8);
        chk("t1_latency", dn, 9);

        run(0, 0, 100, 3, 1'b0, 1'b0, dn);
        chk("start_busy_found", int'(found_w[0]), 100);

        run(0, 0, 255, 0, 1'b0, 1'b1, dn);
        chk("t2_found255", int'(found_w[0]), 255);
        chk("t2_steps255", int'(steps_w[0]), 9);
        run(0, 0, 0, 0, 1'b1, 1'b0, dn);
        chk("t2_found0", int'(found_w[0]), 0);
        chk("t2_steps0", int'(steps_w[0]), 8);

        run(0, 0, 37, 0, 1'b0, 1'b0, dn);
        run(0, 1, 0, 0, 1'b0, 1'b0, dn);
        chk("t3_steps000", int'(steps_w[0]), 1);
        run(0, 2, 0, 0, 1'b0, 1'b0, dn);
        chk("t3_found_gtlt", int'(found_w[0]), 0);

        run(0, 3, 0, 0, 1'b0, 1'b0, dn);
        chk("t4_steps", int'(steps_w[0]), 9);
        chk("t4_no_done", dn, -1);

        // Asynchronous reset after the third probe.
        mode[0] = 0;
        target[0] = 100;
        @(negedge clk);
        start_s[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start_s[0] = 1'b0;
        end
        chk("t5_probe3", int'(probe_w[0]), 95);
        #2 rst_ni = 1'b0;
        #1;
        chk("t5_rst_probe", int'(probe_w[0]), 0);
        chk("t5_rst_flags", int'({busy_w[0], done_w[0], err_w[0]}), 0);
        chk("t5_rst_steps", int'(steps_w[0]), 0);
        @(negedge clk);
        rst_ni = 1'b1;
        run(0, 0, 100, 0, 1'b0, 1'b0, dn);

        // Abort at the fourth probe, with start raised in the same cycle.
        @(negedge clk);
        start_s[0] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start_s[0] = 1'b0;
        end
        abort_s[0] = 1'b1;
        start_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        start_s[0] = 1'b0;
        chk("abort_busy", int'(busy_w[0]), 0);
        chk("abort_pulse", int'({done_w[0], err_w[0]}), 0);
        chk("abort_probe", int'(probe_w[0]), 111);
        chk("abort_steps", int'(steps_w[0]), 4);
        repeat (2) begin
            @(negedge clk);
            chk("abort_idle", int'({busy_w[0], done_w[0], err_w[0]}), 0);
        end

        run(1, 0, 100, 0, 1'b0, 1'b0, dn);
        chk("t6_latency", dn, 25);
        chk("t6_steps", int'(steps_w[1]), 8);
        run(1, 0, 200, 0, 1'b0, 1'b0, dn);
        run(1, 1, 0, 0, 1'b0, 1'b0, dn);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
